// File: rtl/nano_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a circular byte FIFO.
// A TXDATA write (offset 0) queues a byte. A CTRL write (offset 4) with d_data[0]=1 clears the sticky overflow flag.
module nano_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [3:0]  ADDR_TAG     = 4'hF
) (
  input  logic        clock,
  input  logic        not_reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data,
  input  logic        mem_wr,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic [4:0]  fifo_count,
  output logic        overflow
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       DEPTH_C   = 5'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_cpb
    $error("CLKS_PER_BIT must lie in 2..255");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic sel, wr_txdata, wr_ctrl;
  logic push, drop, pop;
  logic baud_done;

  // Bus decode.
  assign sel       = (d_address[31:28] == ADDR_TAG);
  assign wr_txdata = mem_wr && sel && !d_address[2];
  assign wr_ctrl   = mem_wr && sel && d_address[2];

  // A pop on the same edge frees a slot, so a full FIFO can still accept that write.
  assign push      = wr_txdata && ((count_q < DEPTH_C) || pop);
  assign drop      = wr_txdata && !push;
  assign baud_done = (baud_q == BAUD_LAST);

  // NOTE: storage carries no reset; pointers and count define validity, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= d_data[7:0];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + 5'd1;
    else if (pop && !push) count_d = count_q - 5'd1;
    // A dropped push wins over a clear on the same edge.
    if (drop)                     ovf_d = 1'b1;
    else if (wr_ctrl && d_data[0]) ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (count_q != 5'd0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = 8'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = 8'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = 8'd0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = 8'd0;
          // Back-to-back frames: the next byte starts without an idle gap.
          if (count_q != 5'd0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decoded from the next state so that tx itself is a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q  <= IDLE;
      baud_q   <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != 5'd0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  logic unused_bits;
  assign unused_bits = ^{d_address[27:3], d_address[1:0], d_data[31:8]};

endmodule

// File: tb/tb_nano_uart_tx.sv
// Randomized and directed bench for nano_uart_tx.
// The reference model tracks a byte queue and a frame position and derives the line level arithmetically.
module tb_nano_uart_tx;

  localparam int         CPB   = 4;
  localparam int         DEPTH = 4;
  localparam logic [3:0] TAG   = 4'hF;
  localparam int         FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        not_reset = 1'b0;
  logic [31:0] d_address = 32'h0;
  logic [31:0] d_data = 32'h0;
  logic        mem_wr = 1'b0;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic [4:0]  fifo_count;
  logic        overflow;

  always #5 clock = ~clock;

  nano_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_TAG    (TAG)
  ) dut (
    .clock     (clock),
    .not_reset (not_reset),
    .d_address (d_address),
    .d_data    (d_data),
    .mem_wr    (mem_wr),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending bytes, current frame and its position in cycles.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 1'b0;
  int         m_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic wr);
    bit sel, wd, wc, pop;
    sel = (a[31:28] == TAG);
    wd  = wr && sel && !a[2];
    wc  = wr && sel && a[2];
    pop = 1'b0;
    if (m_active) begin
      if (m_pos == FRAME - 1) begin
        m_active = 1'b0;
        pop      = (m_q.size() != 0);
      end else begin
        m_pos++;
      end
    end else begin
      pop = (m_q.size() != 0);
    end
    if (pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
      m_frames++;
    end
    if (wd) begin
      if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
      else                    m_ovf = 1'b1;
    end else if (wc && d[0]) begin
      m_ovf = 1'b0;
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check("tx",         32'(tx),         32'(exp_tx()));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check("busy",       32'(busy),       32'(m_active || m_q.size() != 0));
    check("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic wr);
    d_address = a;
    d_data    = d;
    mem_wr    = wr;
    @(posedge clock);
    model_step(a, d, wr);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(32'h0, 32'h0, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    cycle(32'hF000_0000, {24'h0, b}, 1'b1);
  endtask

  task automatic wait_drained();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (!m_active && m_q.size() == 0) done = 1'b1;
      else idle(1);
    end
    check("drain_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_pos(input int pos, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (m_active && m_pos == pos) hit = 1'b1;
      else idle(1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx"},    32'(tx),         32'd1);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_full"},  32'(fifo_full),  32'd0);
    check({tag, "_ovf"},   32'(overflow),   32'd0);
  endtask

  // Called at a falling edge; asserts reset between edges and releases it two cycles later.
  task automatic mid_reset();
    d_address = 32'h0;
    mem_wr    = 1'b0;
    #2 not_reset = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clock);
    @(negedge clock);
    not_reset = 1'b1;
  endtask

  task automatic random_phase(input int n);
    logic [31:0] a, d;
    logic        wr;
    int          r;
    for (int i = 0; i < n; i++) begin
      a  = $urandom();
      d  = $urandom();
      wr = 1'b1;
      r  = $urandom_range(0, 9);
      if (r < 5) begin
        a[31:28] = TAG;
        a[2]     = 1'b0;
      end else if (r == 5) begin
        a[31:28] = TAG;
        a[2]     = 1'b1;
      end else if (r == 6) begin
        a[31:28] = TAG;
        wr       = 1'b0;
      end else if (r == 7) begin
        a[31:28] = 4'($urandom_range(0, 14));
      end else begin
        wr = 1'b0;
      end
      cycle(a, d, wr);
    end
  endtask

  initial begin
    int exp_slot [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit hit;

    @(negedge clock);
    check_reset_values("reset");
    not_reset = 1'b1;
    idle(3);

    // 0xA5 frame, checked slot by slot against the expected line pattern.
    write_byte(8'hA5);
    for (int k = 0; k < FRAME; k++) begin
      idle(1);
      check("a5_bit", 32'(tx), 32'(exp_slot[k / CPB]));
    end
    idle(1);
    check("a5_done_busy", 32'(busy), 32'd0);
    idle(2);

    // Five back-to-back bytes: one in flight, four queued, no overflow.
    for (int b = 1; b <= 5; b++) write_byte(8'(b));
    check("five_full", 32'(fifo_full),  32'd1);
    check("five_cnt",  32'(fifo_count), 32'd4);
    check("five_ovf",  32'(overflow),   32'd0);
    m_frames = 0;
    wait_drained();
    check("five_frames", 32'(m_frames), 32'd4);

    // Six bytes: the sixth is dropped, then a CTRL write clears the flag.
    for (int b = 0; b < 6; b++) write_byte(8'h10 + 8'(b));
    check("six_ovf", 32'(overflow), 32'd1);
    cycle(32'hF000_0004, 32'h0, 1'b1);
    check("ctrl0_keeps", 32'(overflow), 32'd1);
    cycle(32'hF000_0004, 32'h1, 1'b1);
    check("ctrl_clr", 32'(overflow), 32'd0);

    // Write on the STOP end edge with the FIFO full: accepted, count stays 4.
    wait_pos(FRAME - 1, hit);
    check("stop_wait", 32'(hit), 32'd1);
    check("pre_stop_full", 32'(fifo_full), 32'd1);
    write_byte(8'h77);
    check("stop_cnt",  32'(fifo_count), 32'd4);
    check("stop_ovf",  32'(overflow),   32'd0);
    check("stop_full", 32'(fifo_full),  32'd1);
    wait_drained();

    // Unselected and non-strobed writes are ignored.
    cycle(32'h1000_0000, 32'h55, 1'b1);
    cycle(32'hF000_0000, 32'h55, 1'b0);
    idle(2);
    check("ign_tx",  32'(tx),         32'd1);
    check("ign_cnt", 32'(fifo_count), 32'd0);

    // Reset in the middle of DATA with bytes still queued.
    write_byte(8'h00);
    write_byte(8'h3C);
    write_byte(8'h81);
    wait_pos(3 * CPB + 1, hit);
    check("data_wait", 32'(hit), 32'd1);
    check("pre_rst_tx", 32'(tx), 32'd0);
    mid_reset();
    idle(60);
    check("post_rst_idle", 32'(busy), 32'd0);
    write_byte(8'h5A);
    idle(1);
    check("post_rst_start", 32'(tx), 32'd0);
    wait_drained();

    random_phase(600);
    wait_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nano_uart_tx.md
NANO_UART_TX -- requirements
Module: nano_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, sets the clock cycles per serial bit (legal values 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4, sets the number of transmit byte entries (power of two, 2..16).
REQ-003 Parameter ADDR_TAG, default 4'hF, is the block select value compared against d_address[31:28].
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  system clock; all state changes on the rising edge.
REQ-006 not_reset  input  1  asynchronous active-low reset.
REQ-007 d_address  input  32  CPU data address bus.
REQ-008 d_data  input  32  CPU write data; only bits [7:0] and bit 0 are used.
REQ-009 mem_wr  input  1  CPU write strobe, sampled on the rising edge of clock.
REQ-010 tx  output  1  serial line, 8N1 format, LSB first, idle high.
REQ-011 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-012 fifo_full  output  1  high when the FIFO count equals FIFO_DEPTH.
REQ-013 fifo_count  output  5  number of bytes queued, excluding the byte being shifted.
REQ-014 overflow  output  1  sticky flag set when a write is dropped.

Function
REQ-015 The block SHALL be selected when d_address[31:28]==ADDR_TAG; d_address[27:3] are don't-care.
REQ-016 A TXDATA write SHALL be mem_wr=1 with select and d_address[2]==0; it pushes d_data[7:0].
REQ-017 A CTRL write SHALL be mem_wr=1 with select and d_address[2]==1; d_data[0]=1 clears overflow, other bits are ignored.
REQ-018 A push SHALL be accepted when fifo_count<FIFO_DEPTH, or when a pop occurs on the same edge.
REQ-019 A push in any other case SHALL be dropped, leaving the FIFO unchanged, and SHALL set overflow.
REQ-020 If a dropped push and a CTRL clear occur on the same edge, overflow SHALL end set.
REQ-021 The FIFO SHALL use circular read and write pointers that wrap modulo FIFO_DEPTH.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 FSM states: IDLE, START, DATA, STOP.
REQ-024 In IDLE with fifo_count>0, the FSM SHALL pop the head byte into the shift register and go to START on the same edge.
REQ-025 tx SHALL be registered: 0 in START, shift[bit_idx] in DATA, 1 in STOP and IDLE.
REQ-026 A baud counter SHALL count 0..CLKS_PER_BIT-1 in each bit state, and the state or bit advances when it reaches CLKS_PER_BIT-1.
REQ-027 DATA SHALL send bits 0..7 using a 3-bit index, then go to STOP.
REQ-028 At the end of STOP, the FSM SHALL pop and go to START if fifo_count>0, with no idle gap; otherwise it goes to IDLE.
REQ-029 Latency: a TXDATA write at edge N into an empty FIFO with FSM IDLE SHALL drive tx=0 from edge N+1.
REQ-030 A frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-031 Writes with mem_wr=0, or without select, SHALL have no effect.

Reset
REQ-032 not_reset=0 SHALL immediately force tx=1, FSM=IDLE, counters and pointers to 0, fifo_count=0, overflow=0, busy=0, and fifo_full=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame and discard all queued bytes; tx returns high without waiting for a clock.
REQ-034 After reset is released, the first accepted write SHALL behave as in REQ-029.

Verification
REQ-035 Reset, then write 0xA5 to 0xF000_0000 with CLKS_PER_BIT=4 -> tx from edge N+1: 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1; busy=0 after 40 cycles.
REQ-036 Write five bytes back-to-back (0x01..0x05) -> first byte popped, four queued, fifo_full=1, no overflow; all five frames are sent contiguously with no idle gap.
REQ-037 Write six bytes while the first is still shifting -> sixth byte dropped, overflow=1; a CTRL write with d_data=1 to 0xF000_0004 -> overflow=0.
REQ-038 With the FIFO full, write on the STOP end edge -> write accepted, fifo_count stays 4, no overflow.
REQ-039 Assert not_reset=0 in the middle of DATA -> tx=1 with no clock edge; fifo_count=0; no further frames after release.
REQ-040 Write to 0x1000_0000 with mem_wr=1, and to 0xF000_0000 with mem_wr=0 -> tx stays 1 and fifo_count stays 0.
